// File: rtl/pipe_pkg.sv
// Shared types and helpers for the PIPE 128b/130b transmit block packer.
// Build option PIPE_TX_DATAVALID_GAP_EN adds the TxDataValid gap state.
package pipe_pkg;

  localparam int BLOCK_BITS = 128;

  // Per-lane TxData width actually used for a block
  typedef enum logic [1:0] {
    W8  = 2'd0,
    W16 = 2'd1,
    W32 = 2'd2
  } width_e;

`ifdef PIPE_TX_DATAVALID_GAP_EN
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_GAP  = 2'd2
  } state_e;
`else
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1
  } state_e;
`endif

  // Beats needed to move one 128-bit block at the given width
  function automatic logic [4:0] beats_per_block(input width_e w);
    case (w)
      W8:      return 5'd16;
      W16:     return 5'd8;
      default: return 5'd4;
    endcase
  endfunction

  // Blocks between gaps: 2 header bits per block accumulate to one beat of W bits
  function automatic logic [4:0] blocks_per_gap(input width_e w);
    case (w)
      W8:      return 5'd4;
      W16:     return 5'd8;
      default: return 5'd16;
    endcase
  endfunction

  // Decode width select, clamping 3 and anything wider than the physical bus
  function automatic width_e eff_width(input logic [1:0] sel, input int max_w);
    width_e w;
    case (sel)
      2'd0:    w = W8;
      2'd1:    w = W16;
      default: w = W32;
    endcase
    if (w == W32 && max_w < 32) w = W16;
    if (w == W16 && max_w < 16) w = W8;
    return w;
  endfunction

endpackage

// File: rtl/pipe_tx_lane_slicer.sv
// One lane's registered beat mux: picks W bits of a 128-bit block for a beat index,
// zero-pads to MAX_WIDTH; can clear to 0 or hold the previous beat.
module pipe_tx_lane_slicer
  import pipe_pkg::*;
#(
  parameter int MAX_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [BLOCK_BITS-1:0] i_blk,
  input  logic [3:0]            i_beat,
  input  width_e                i_width,
  input  logic                  i_load,
  input  logic                  i_clr,
  output logic [MAX_WIDTH-1:0]  o_data
);

  logic [31:0] w_slice;

  // Select the beat's bits, LSB first, upper bits zero
  always_comb begin
    w_slice = '0;
    case (i_width)
      W8:      w_slice = {24'd0, i_blk[{i_beat, 3'b000} +: 8]};
      W16:     w_slice = {16'd0, i_blk[{i_beat[2:0], 4'b0000} +: 16]};
      default: w_slice = i_blk[{i_beat[1:0], 5'b00000} +: 32];
    endcase
  end

  // Output register: clear wins over load, otherwise hold
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)      o_data <= '0;
    else if (i_clr)  o_data <= '0;
    else if (i_load) o_data <= w_slice[MAX_WIDTH-1:0];
  end

endmodule

// File: rtl/pipe_tx_block_packer.sv
// PIPE TX packer for 128b/130b: takes whole blocks for all lanes and serialises
// them at 8/16/32 bits per lane. Define PIPE_TX_DATAVALID_GAP_EN to insert one
// TxDataValid=0 cycle after every G blocks.
//
// state   | meaning
// IDLE    | no block in flight, outputs 0, ready for a block
// SEND    | driving beat r_beat of the latched block
// GAP     | one dead cycle (valid low, data held), ready for a block
module pipe_tx_block_packer
  import pipe_pkg::*;
#(
  parameter int LANES     = 16,
  parameter int MAX_WIDTH = 32
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [1:0]                  width_i,
  input  logic                        blk_valid,
  output logic                        blk_ready,
  input  logic [LANES*BLOCK_BITS-1:0] blk_data,
  input  logic [2*LANES-1:0]          blk_sync,
  output logic [LANES*MAX_WIDTH-1:0]  TxData,
  output logic [LANES-1:0]            TxDataValid,
  output logic [LANES-1:0]            TxStartBlock,
  output logic [2*LANES-1:0]          TxSynchHeader,
  output logic                        busy
);

  state_e                      r_state;
  state_e                      w_state_nxt;
  logic [3:0]                  r_beat;
  width_e                      r_width;
  logic [LANES*BLOCK_BITS-1:0] r_blk;

  width_e                      w_width_eff;
  width_e                      w_width_slc;
  logic                        w_last;
  logic                        w_accept;
  logic                        w_load;
  logic                        w_clr;
  logic                        w_start;
  logic [3:0]                  w_beat_nxt;

`ifdef PIPE_TX_DATAVALID_GAP_EN
  logic [4:0]                  r_gap_cnt;
  logic                        w_gap_due;

  assign w_gap_due = ((r_gap_cnt + 5'd1) == blocks_per_gap(r_width));
`endif

  assign w_width_eff = eff_width(width_i, MAX_WIDTH);
  // Width is only taken from width_i when starting from IDLE
  assign w_width_slc = (r_state == ST_IDLE) ? w_width_eff : r_width;
  assign w_last      = ({1'b0, r_beat} == (beats_per_block(r_width) - 5'd1));
  assign w_accept    = blk_valid && blk_ready;
  assign busy        = (r_state != ST_IDLE);

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (blk_valid) w_state_nxt = ST_SEND;
      ST_SEND: begin
        if (w_last) begin
`ifdef PIPE_TX_DATAVALID_GAP_EN
          if (w_gap_due)      w_state_nxt = ST_GAP;
          else
`endif
          if (blk_valid)      w_state_nxt = ST_SEND;
          else                w_state_nxt = ST_IDLE;
        end
      end
`ifdef PIPE_TX_DATAVALID_GAP_EN
      ST_GAP:  w_state_nxt = blk_valid ? ST_SEND : ST_IDLE;
`endif
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Handshake and datapath controls; ready without accept always means IDLE next
  always_comb begin
    blk_ready  = 1'b0;
    w_load     = 1'b0;
    w_clr      = 1'b0;
    w_start    = 1'b0;
    w_beat_nxt = r_beat;
    case (r_state)
      ST_IDLE: blk_ready = 1'b1;
      ST_SEND: begin
        if (!w_last) begin
          w_load     = 1'b1;
          w_beat_nxt = r_beat + 4'd1;
        end else begin
`ifdef PIPE_TX_DATAVALID_GAP_EN
          blk_ready = !w_gap_due;
`else
          blk_ready = 1'b1;
`endif
        end
      end
`ifdef PIPE_TX_DATAVALID_GAP_EN
      ST_GAP:  blk_ready = 1'b1;
`endif
      default: blk_ready = 1'b0;
    endcase
    if (blk_valid && blk_ready) begin
      w_load     = 1'b1;
      w_start    = 1'b1;
      w_beat_nxt = '0;
    end else if (blk_ready) begin
      w_clr      = 1'b1;
      w_beat_nxt = '0;
    end
  end

  // Block latch, beat index and lane-common PIPE qualifiers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_blk         <= '0;
      r_width       <= W8;
      r_beat        <= '0;
      TxDataValid   <= '0;
      TxStartBlock  <= '0;
      TxSynchHeader <= '0;
    end else begin
      if (w_accept) r_blk <= blk_data;
      if (w_accept && r_state == ST_IDLE) r_width <= w_width_eff;
      r_beat        <= w_beat_nxt;
      TxDataValid   <= {LANES{w_load}};
      TxStartBlock  <= {LANES{w_start}};
      TxSynchHeader <= w_start ? blk_sync : '0;
    end
  end

`ifdef PIPE_TX_DATAVALID_GAP_EN
  // Completed-block counter; cleared on gap and whenever the stream stops
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_gap_cnt <= '0;
    end else if (r_state == ST_SEND && w_last) begin
      if (w_gap_due || !w_accept) r_gap_cnt <= '0;
      else                        r_gap_cnt <= r_gap_cnt + 5'd1;
    end
  end
`endif

  for (genvar n = 0; n < LANES; n++) begin : g_lane
    logic [BLOCK_BITS-1:0] w_lane_blk;

    // A newly accepted block feeds beat 0 straight from the input bus
    assign w_lane_blk = w_accept ? blk_data[n*BLOCK_BITS +: BLOCK_BITS]
                                 : r_blk[n*BLOCK_BITS +: BLOCK_BITS];

    pipe_tx_lane_slicer #(
      .MAX_WIDTH(MAX_WIDTH)
    ) u_slicer (
      .clk    (clk),
      .reset  (reset),
      .i_blk  (w_lane_blk),
      .i_beat (w_beat_nxt),
      .i_width(w_width_slc),
      .i_load (w_load),
      .i_clr  (w_clr),
      .o_data (TxData[n*MAX_WIDTH +: MAX_WIDTH])
    );
  end

endmodule

// File: tb/tb_pipe_tx_block_packer.sv
// Bench for pipe_tx_block_packer: 4 lanes, 32-bit physical width.
module tb_pipe_tx_block_packer;

  localparam int LANES = 4;
  localparam int MW    = 32;

  logic                  clk;
  logic                  reset;
  logic [1:0]            width_i;
  logic                  blk_valid;
  logic                  blk_ready;
  logic [LANES*128-1:0]  blk_data;
  logic [2*LANES-1:0]    blk_sync;
  logic [LANES*MW-1:0]   TxData;
  logic [LANES-1:0]      TxDataValid;
  logic [LANES-1:0]      TxStartBlock;
  logic [2*LANES-1:0]    TxSynchHeader;
  logic                  busy;

  pipe_tx_block_packer #(.LANES(LANES), .MAX_WIDTH(MW)) dut (
    .clk          (clk),
    .reset        (reset),
    .width_i      (width_i),
    .blk_valid    (blk_valid),
    .blk_ready    (blk_ready),
    .blk_data     (blk_data),
    .blk_sync     (blk_sync),
    .TxData       (TxData),
    .TxDataValid  (TxDataValid),
    .TxStartBlock (TxStartBlock),
    .TxSynchHeader(TxSynchHeader),
    .busy         (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [LANES*MW-1:0]  data;
    logic [LANES-1:0]     start;
    logic [2*LANES-1:0]   sync;
  } beat_t;

  typedef struct {
    logic [1:0]   wsel;
    logic [127:0] data;
    logic [1:0]   sync;
    int           exp_w;
    logic [31:0]  exp_first;
    logic [31:0]  exp_last;
  } vec_t;

  beat_t        q[$];
  vec_t         tbl[6];
  int           errors = 0;
  int           checks = 0;
  int           mon_beats = 0;
  logic [31:0]  mon_first = '0;
  logic [31:0]  mon_last = '0;
  logic         sv[0:80];
  logic         ss[0:80];
  logic [LANES*MW-1:0] sd[0:80];

  task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Expected beats for one block, straight from the lane/beat bit-order rule
  task automatic push_block(input logic [LANES*128-1:0] bd, input logic [2*LANES-1:0] bs, input int w);
    beat_t        b;
    logic [127:0] sh;
    logic [31:0]  mask;
    mask = (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    for (int k = 0; k < 128 / w; k++) begin
      for (int n = 0; n < LANES; n++) begin
        sh = bd[n*128 +: 128] >> (k * w);
        b.data[n*MW +: MW] = sh[31:0] & mask;
      end
      b.start = (k == 0) ? '1 : '0;
      b.sync  = (k == 0) ? bs : '0;
      q.push_back(b);
    end
  endtask

  // Drive a block (lane n = d ^ n*0x11 pattern) and hold it until accepted
  task automatic send_block(input logic [127:0] d, input logic [1:0] s, input int w);
    logic [LANES*128-1:0] bd;
    logic [2*LANES-1:0]   bs;
    logic [7:0]           pat;
    int                   t;
    for (int n = 0; n < LANES; n++) begin
      pat = 8'(n) * 8'h11;
      bd[n*128 +: 128] = d ^ {16{pat}};
      bs[2*n +: 2]     = s ^ 2'(n);
    end
    @(negedge clk);
    blk_data  = bd;
    blk_sync  = bs;
    blk_valid = 1'b1;
    t = 0;
    while (!blk_ready && t < 300) begin
      @(negedge clk);
      t++;
    end
    if (!blk_ready) begin
      errors++;
      checks++;
      $display("FAIL send_timeout: ready never seen");
      blk_valid = 1'b0;
    end else begin
      push_block(bd, bs, w);
      @(posedge clk);
    end
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    @(negedge clk);
    while (busy && n < 500) begin
      n++;
      @(negedge clk);
    end
    if (busy) begin
      errors++;
      checks++;
      $display("FAIL idle_timeout: busy stuck");
    end
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Stream nblk blocks, then reset while the last one shows beat 2
  task automatic reset_mid(input logic [1:0] wsel, input int nblk, input int w);
    width_i = wsel;
    for (int i = 0; i < nblk; i++) send_block(rnd128(), 2'b10, w);
    #1 blk_valid = 1'b0;
    repeat (3) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    chk("rst_mid_out", 160'({TxDataValid, TxStartBlock, TxSynchHeader, TxData}), 160'(0));
    chk("rst_mid_hs", 160'({blk_ready, busy}), 160'(2'b10));
    q.delete();
    @(negedge clk);
    reset = 1'b1;
  endtask

  // Scoreboard and idle-output monitor
  always @(negedge clk) begin
    beat_t e;
    if (reset) begin
      if (TxDataValid[0]) begin
        chk("valid_lanes", 160'(TxDataValid), 160'({LANES{1'b1}}));
        if (q.size() == 0) begin
          errors++;
          checks++;
          $display("FAIL beat_unexpected: data %0h", TxData);
        end else begin
          e = q.pop_front();
          chk("beat_data", 160'(TxData), 160'(e.data));
          chk("beat_hdr", 160'({TxStartBlock, TxSynchHeader}), 160'({e.start, e.sync}));
        end
        mon_beats++;
        if (TxStartBlock[0]) mon_first = TxData[31:0];
        mon_last = TxData[31:0];
      end else begin
        chk("novalid_hdr", 160'({TxDataValid, TxStartBlock, TxSynchHeader}), 160'(0));
        if (!busy) chk("idle_out", 160'({blk_ready, TxData}), 160'({1'b1, {LANES*MW{1'b0}}}));
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit");
    $fatal(1);
  end

  initial begin
    int n;
    int cnt;
    tbl[0] = '{2'd2, 128'h00112233_44556677_8899AABB_CCDDEEFF, 2'b10, 32, 32'hCCDDEEFF, 32'h00112233};
    tbl[1] = '{2'd0, 128'h00112233_44556677_8899AABB_CCDDEEFF, 2'b01,  8, 32'h000000FF, 32'h00000000};
    tbl[2] = '{2'd1, 128'h00112233_44556677_8899AABB_CCDDEEFF, 2'b10, 16, 32'h0000EEFF, 32'h00000011};
    tbl[3] = '{2'd3, 128'h00112233_44556677_8899AABB_CCDDEEFF, 2'b01, 32, 32'hCCDDEEFF, 32'h00112233};
    tbl[4] = '{2'd1, 128'hDEADBEEF_01234567_89ABCDEF_FEDCBA98, 2'b10, 16, 32'h0000BA98, 32'h0000DEAD};
    tbl[5] = '{2'd0, 128'hDEADBEEF_01234567_89ABCDEF_FEDCBA98, 2'b01,  8, 32'h00000098, 32'h000000DE};

    reset     = 1'b0;
    width_i   = 2'd0;
    blk_valid = 1'b0;
    blk_data  = '0;
    blk_sync  = '0;
    repeat (3) @(negedge clk);
    chk("reset_out", 160'({TxDataValid, TxStartBlock, TxSynchHeader, TxData}), 160'(0));
    chk("reset_hs", 160'({blk_ready, busy}), 160'(2'b10));
    reset = 1'b1;

    // Single blocks at each width select
    foreach (tbl[i]) begin
      width_i   = tbl[i].wsel;
      mon_beats = 0;
      send_block(tbl[i].data, tbl[i].sync, tbl[i].exp_w);
      #1 blk_valid = 1'b0;
      wait_idle(n);
      chk("tbl_busy_cycles", 160'(n), 160'(128 / tbl[i].exp_w));
      chk("tbl_beats", 160'(mon_beats), 160'(128 / tbl[i].exp_w));
      chk("tbl_first", 160'(mon_first), 160'(tbl[i].exp_first));
      chk("tbl_last", 160'(mon_last), 160'(tbl[i].exp_last));
    end

    // width_i change mid-stream is ignored until the next start from IDLE
    width_i   = 2'd2;
    mon_beats = 0;
    send_block(rnd128(), 2'b01, 32);
    #1 width_i = 2'd0;
    send_block(rnd128(), 2'b10, 32);
    send_block(rnd128(), 2'b01, 32);
    #1 blk_valid = 1'b0;
    wait_idle(n);
    chk("wchg_tail", 160'(n), 160'(4));
    chk("wchg_beats", 160'(mon_beats), 160'(12));
    send_block(rnd128(), 2'b10, 8);
    #1 blk_valid = 1'b0;
    wait_idle(n);
    chk("wchg_after_idle", 160'(n), 160'(16));

    // Reset during a block, then stale-counter probe (2 W8 blocks before reset)
    reset_mid(2'd2, 1, 32);
    reset_mid(2'd0, 2, 8);

`ifdef PIPE_TX_DATAVALID_GAP_EN
    width_i = 2'd0;
    send_block(rnd128(), 2'b01, 8);
    fork
      begin
        for (int i = 0; i < 4; i++) send_block(rnd128(), 2'b10, 8);
        #1 blk_valid = 1'b0;
      end
      begin
        for (int i = 0; i < 66; i++) begin
          @(negedge clk);
          sv[i] = TxDataValid[0];
          ss[i] = TxStartBlock[0];
          sd[i] = TxData;
        end
      end
    join
    cnt = 0;
    for (int i = 0; i < 64; i++) cnt += int'(sv[i]);
    chk("gap_valid_run", 160'(cnt), 160'(64));
    chk("gap_b2_start", 160'(ss[16]), 160'(1));
    chk("gap_cycle", 160'(sv[64]), 160'(0));
    chk("gap_data_held", 160'(sd[64]), 160'(sd[63]));
    chk("gap_b5_start", 160'({sv[65], ss[65]}), 160'(2'b11));
    wait_idle(n);
`else
    width_i = 2'd2;
    send_block(rnd128(), 2'b01, 32);
    fork
      begin
        for (int i = 0; i < 19; i++) send_block(rnd128(), 2'b10, 32);
        #1 blk_valid = 1'b0;
      end
      begin
        for (int i = 0; i < 81; i++) begin
          @(negedge clk);
          sv[i] = TxDataValid[0];
          ss[i] = TxStartBlock[0];
          sd[i] = TxData;
        end
      end
    join
    cnt = 0;
    for (int i = 0; i < 80; i++) cnt += int'(sv[i]);
    chk("nogap_valid_run", 160'(cnt), 160'(80));
    chk("nogap_b20_start", 160'(ss[76]), 160'(1));
    chk("nogap_end", 160'(sv[80]), 160'(0));
    wait_idle(n);
`endif

    chk("sb_empty", 160'(q.size()), 160'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pipe_tx_block_packer.md
# pipe_tx_block_packer

Parametrised MAC-side transmit packer for the PIPE interface at 128b/130b rates (Gen3 and above). Accepts whole 128-bit blocks plus 2-bit sync headers for all lanes in lockstep over a valid/ready handshake. Serialises each block onto TxData at the per-lane width selected at run time (8/16/32 bits), driving TxDataValid, TxStartBlock and TxSynchHeader. Sits between the link-layer block generator and the PIPE TX signals of the PHY.

## Interface
- LANES, 16, lane count (1..16)
- MAX_WIDTH, 32, physical per-lane TxData width (8, 16 or 32)
- clk  in  1  PIPE clock (PCLK); all logic on rising edge
- reset  in  1  asynchronous, active-low reset
- width_i  in  2  per-lane width: 0=8b, 1=16b, 2=32b; 3, or any value above MAX_WIDTH, is treated as MAX_WIDTH
- blk_valid  in  1  block available
- blk_ready  out  1  block accepted when blk_valid && blk_ready
- blk_data  in  LANES*128  lane n payload at [128n+127:128n]
- blk_sync  in  2*LANES  lane n sync header at [2n+1:2n]
- TxData  out  LANES*MAX_WIDTH  lane n at [n*MAX_WIDTH +: MAX_WIDTH]
- TxDataValid  out  LANES  beat qualifier; all bits identical
- TxStartBlock  out  LANES  first beat of a block
- TxSynchHeader  out  2*LANES  valid while TxStartBlock=1, else 0
- busy  out  1  state != IDLE

## Operation
- FSM states:
  - IDLE: blk_ready=1. On accept, latch block and effective width W, go to SEND with beat=0.
  - SEND: drive beat of 128/W beats (16/8/4). Beat k carries payload bits [kW+W-1:kW], LSB first. TxStartBlock=1 only at k=0. On the last beat:
    - Gap due: go to GAP.
    - Otherwise, if blk_valid, accept the next block back-to-back (no bubble).
    - Otherwise go to IDLE.
  - GAP: exactly one cycle with TxDataValid=0, TxStartBlock=0, TxData unchanged. blk_ready=1; accept goes to SEND, else IDLE.
- blk_ready is high in IDLE, in GAP, and in SEND on the last beat when no gap is due; it is low otherwise.
- Gap counter counts completed blocks. A gap is due after G consecutive blocks, with G=4/8/16 for W=8/16/32, i.e. 2 header bits per block times G equals W. The counter clears on gap and on entering IDLE.
- width_i is sampled only on acceptance from IDLE. It is ignored while streaming, including back-to-back and post-GAP accepts.
- Lane bits above W in TxData are driven 0.
- Reset mid-block: the block is discarded, all outputs go to reset values immediately, and the counter is cleared.

## Timing
- Reset values:
  - TxData=0, TxDataValid=0, TxStartBlock=0, TxSynchHeader=0.
  - blk_ready=1, busy=0, FSM=IDLE, beat=0, gap count=0.
- All PIPE outputs are registered. A block accepted at edge N shows its first beat after edge N, so TxStartBlock is visible in cycle N+1.
- Sustained throughput is G blocks per G*(128/W)+1 cycles when the gap feature is enabled.
- In IDLE all PIPE outputs are 0.

## Configuration
- PIPE_TX_DATAVALID_GAP_EN:
  - Defined: GAP state and gap counter as above.
  - Undefined: the GAP state and counter are not compiled. TxDataValid stays 1 for every beat, and last-beat behaviour is the same as "no gap due". This mode is for PHYs where PCLK already accounts for the 130/128 overhead.

## Structure
- pipe_pkg holds:
  - width enum (W8/W16/W32)
  - constant BLOCK_BITS=128
  - functions beats_per_block(width) and blocks_per_gap(width)
  - FSM state typedef
- Sub-module pipe_tx_lane_slicer is instantiated LANES times. It is a per-lane registered beat mux: 128-bit block, beat index and W in, MAX_WIDTH-bit zero-padded slice out. The parent holds the FSM, counters and handshake.

## Test plan
- LANES=1, W=32, one block 0x00112233_44556677_8899AABB_CCDDEEFF, sync=2'b10:
  - Beats 0xCCDDEEFF, 0x8899AABB, 0x44556677, 0x00112233.
  - TxStartBlock and TxSynchHeader=2'b10 only on beat 0.
  - busy drops one cycle after the last beat.
- W=8, gap enabled, continuous blk_valid for 5 blocks:
  - 4×16 valid beats with no bubble between blocks.
  - Then one cycle TxDataValid=0 with TxData held.
  - Block 5 starts the next cycle.
- W=16, MAX_WIDTH=32, LANES=4, distinct per-lane data: 8 beats per block, upper 16 bits of each lane =0, lanes independent.
- width_i changed from 2 to 0 mid-block: the current and back-to-back blocks stay at 4 beats. The 8-bit width applies only after returning to IDLE.
- reset asserted at beat 2 of a W=32 block: next cycle all outputs 0, blk_ready=1. A new block after release starts at beat 0 with the gap counter at 0.
- Gap disabled build, W=32, 20 back-to-back blocks: 80 consecutive TxDataValid=1 cycles, none low.
